// File: rtl/stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall controller.
// Stall vectors are thermometer codes: bit k set holds pipeline stage k.
package stall_ctrl_pkg;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic RstEnable = 1'b1;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_BUSY = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/stall_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall controller.
// The pipeline side is the master; the controller is the slave.
interface stall_ctrl_if #(parameter int unsigned CNT_W = 6);

    logic             stallreq_from_if;
    logic             stallreq_from_id;
    logic             stallreq_from_ex;
    logic             stallreq_from_mem;
    logic             ex_multi_start;
    logic [CNT_W-1:0] ex_multi_cycles;
    logic             perf_clr;
    logic [5:0]       stall;
    logic             ex_multi_busy;
    logic             ex_multi_done;
    logic [31:0]      stall_cycles;

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output ex_multi_start, ex_multi_cycles, perf_clr,
        input  stall, ex_multi_busy, ex_multi_done, stall_cycles
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  ex_multi_start, ex_multi_cycles, perf_clr,
        output stall, ex_multi_busy, ex_multi_done, stall_cycles
    );

endinterface

// File: rtl/stall_ctrl_multi_cycle_seq.sv
// Multi-cycle EX sequencer: holds EX for N productive cycles, then strobes done
// until MEM releases, so the result strobe cannot be lost under a MEM stall.
module multi_cycle_seq
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_multi_start,
    input  logic [CNT_W-1:0] ex_multi_cycles,
    input  logic             stallreq_from_mem,
    output logic             ex_hold,
    output logic             ex_multi_busy,
    output logic             ex_multi_done
);

    seq_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             start_ok;

    assign start_ok = ex_multi_start && (ex_multi_cycles != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state <= SEQ_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The start cycle itself counts as a held cycle unless MEM is stalling it.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            SEQ_IDLE: begin
                if (start_ok) begin
                    cnt_next   = stallreq_from_mem ? ex_multi_cycles
                                                   : ex_multi_cycles - CNT_W'(1);
                    state_next = (cnt_next == '0) ? SEQ_DONE : SEQ_BUSY;
                end
            end
            SEQ_BUSY: begin
                if (!stallreq_from_mem) begin
                    cnt_next = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state_next = SEQ_DONE;
                    end
                end
            end
            SEQ_DONE: begin
                if (!stallreq_from_mem) begin
                    state_next = SEQ_IDLE;
                end
            end
            default: begin
                state_next = SEQ_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        ex_hold       = (state == SEQ_BUSY) || ((state == SEQ_IDLE) && start_ok);
        ex_multi_busy = (state == SEQ_BUSY);
        ex_multi_done = (state == SEQ_DONE);
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: deepest-stage-wins priority encoder for the stall
// vector, multi-cycle EX sequencer and a saturating stall-cycle counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    stall_ctrl_if.slave  bus
);

    logic        ex_hold;
    logic [5:0]  stall_vec;
    logic [31:0] cycle_cnt;

    multi_cycle_seq #(.CNT_W(CNT_W)) u_seq (
        .clk               (clk),
        .rst               (rst),
        .ex_multi_start    (bus.ex_multi_start),
        .ex_multi_cycles   (bus.ex_multi_cycles),
        .stallreq_from_mem (bus.stallreq_from_mem),
        .ex_hold           (ex_hold),
        .ex_multi_busy     (bus.ex_multi_busy),
        .ex_multi_done     (bus.ex_multi_done)
    );

    // Purely combinational so every pipeline register sees the stall in the request cycle.
    always_comb begin
        stall_vec = STALL_NONE;
        if (rst == RstEnable) begin
            stall_vec = STALL_NONE;
        end else if (bus.stallreq_from_mem) begin
            stall_vec = STALL_MEM;
        end else if (bus.stallreq_from_ex || ex_hold) begin
            stall_vec = STALL_EX;
        end else if (bus.stallreq_from_id) begin
            stall_vec = STALL_ID;
        end else if (bus.stallreq_from_if) begin
            stall_vec = STALL_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            cycle_cnt <= '0;
        end else if (bus.perf_clr) begin
            cycle_cnt <= '0;
        end else if ((stall_vec[0] == Stop) && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign bus.stall        = stall_vec;
    assign bus.stall_cycles = cycle_cnt;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_stall_ctrl;

    logic clk;
    logic rst;
    stall_ctrl_if #(.CNT_W(6)) bus ();

    stall_ctrl #(.CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit preload_now = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Deepest requesting stage d (1..5 ones) gives a run of d low ones.
    function automatic logic [5:0] stall_of(input bit i, input bit d, input bit e, input bit m);
        int ones;
        ones = m ? 5 : e ? 4 : d ? 3 : i ? 2 : 0;
        return 6'((1 << ones) - 1);
    endfunction

    // Model: an operation needs `need` more non-MEM-stalled held cycles,
    // then reports done until a cycle passes without a MEM stall.
    bit          in_op = 1'b0;
    int          need  = 0;
    logic [31:0] mdl_cnt = '0;
    bit          m_start, m_hold;
    logic [5:0]  m_stall;

    always @(negedge clk) begin
        if (preload_now) mdl_cnt = 32'hFFFF_FFFE;
        if (rst) begin
            in_op   = 1'b0;
            need    = 0;
            mdl_cnt = '0;
            check("rst_stall", 64'(bus.stall), 64'd0);
            check("rst_busy",  64'(bus.ex_multi_busy), 64'd0);
            check("rst_done",  64'(bus.ex_multi_done), 64'd0);
            check("rst_cnt",   64'(bus.stall_cycles), 64'd0);
        end else begin
            m_start = !in_op && bus.ex_multi_start && (bus.ex_multi_cycles != 0);
            m_hold  = m_start || (in_op && need > 0);
            m_stall = stall_of(bus.stallreq_from_if, bus.stallreq_from_id,
                               bus.stallreq_from_ex || m_hold, bus.stallreq_from_mem);
            check("mdl_stall", 64'(bus.stall), 64'(m_stall));
            check("mdl_busy",  64'(bus.ex_multi_busy), 64'(in_op && need > 0));
            check("mdl_done",  64'(bus.ex_multi_done), 64'(in_op && need == 0));
            check("mdl_cnt",   64'(bus.stall_cycles), 64'(mdl_cnt));
            if (m_start) begin
                in_op = 1'b1;
                need  = int'(bus.ex_multi_cycles) - (bus.stallreq_from_mem ? 0 : 1);
            end else if (in_op && need > 0) begin
                if (!bus.stallreq_from_mem) need--;
            end else if (in_op) begin
                if (!bus.stallreq_from_mem) in_op = 1'b0;
            end
            if (bus.perf_clr) mdl_cnt = '0;
            else if (m_stall[0] && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.stallreq_from_if  = 1'b0;
        bus.stallreq_from_id  = 1'b0;
        bus.stallreq_from_ex  = 1'b0;
        bus.stallreq_from_mem = 1'b0;
        bus.ex_multi_start    = 1'b0;
        bus.ex_multi_cycles   = '0;
        bus.perf_clr          = 1'b0;
    endtask

    task automatic chk(input string name, input logic [5:0] s, input bit b, input bit d);
        #1;
        check({name, "_stall"}, 64'(bus.stall), 64'(s));
        check({name, "_busy"},  64'(bus.ex_multi_busy), 64'(b));
        check({name, "_done"},  64'(bus.ex_multi_done), 64'(d));
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        step();
        step();
        rst = 1'b0;
        step();

        // Reset in the middle of a long hold
        bus.ex_multi_start = 1'b1;
        bus.ex_multi_cycles = 6'd20;
        chk("t1_c1", 6'b001111, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            idle_in();
            chk("t1_hold", 6'b001111, 1, 0);
        end
        step();
        rst = 1'b1;
        chk("t1_async", 6'b000000, 0, 0);
        step();
        rst = 1'b0;
        chk("t1_after", 6'b000000, 0, 0);
        check("t1_cnt", 64'(bus.stall_cycles), 64'd0);
        step();
        chk("t1_after2", 6'b000000, 0, 0);

        // N = 4 without interference
        bus.ex_multi_start = 1'b1;
        bus.ex_multi_cycles = 6'd4;
        chk("t3_c1", 6'b001111, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            idle_in();
            chk("t3_hold", 6'b001111, 1, 0);
        end
        step();
        chk("t3_c5", 6'b000000, 0, 1);
        check("t3_cnt", 64'(bus.stall_cycles), 64'd4);
        step();
        chk("t3_c6", 6'b000000, 0, 0);

        // Priority among simultaneous requests
        step();
        bus.stallreq_from_if = 1'b1;
        bus.stallreq_from_id = 1'b1;
        bus.stallreq_from_mem = 1'b1;
        chk("t2_all", 6'b011111, 0, 0);
        bus.stallreq_from_mem = 1'b0;
        chk("t2_nomem", 6'b000111, 0, 0);
        bus.stallreq_from_id = 1'b0;
        chk("t2_ifonly", 6'b000011, 0, 0);
        step();
        idle_in();

        // N = 3 with MEM interference during the hold and during done
        step();
        bus.ex_multi_start = 1'b1;
        bus.ex_multi_cycles = 6'd3;
        chk("t4_c1", 6'b001111, 0, 0);
        step();
        idle_in();
        bus.stallreq_from_mem = 1'b1;
        chk("t4_c2", 6'b011111, 1, 0);
        step();
        chk("t4_c3", 6'b011111, 1, 0);
        step();
        bus.stallreq_from_mem = 1'b0;
        chk("t4_c4", 6'b001111, 1, 0);
        step();
        chk("t4_c5", 6'b001111, 1, 0);
        step();
        bus.stallreq_from_mem = 1'b1;
        chk("t4_c6", 6'b011111, 0, 1);
        step();
        chk("t4_c7", 6'b011111, 0, 1);
        step();
        bus.stallreq_from_mem = 1'b0;
        chk("t4_c8", 6'b000000, 0, 1);
        step();
        chk("t4_c9", 6'b000000, 0, 0);

        // N = 0 is ignored; a second start while busy is ignored
        step();
        bus.ex_multi_start = 1'b1;
        bus.ex_multi_cycles = 6'd0;
        chk("t5_zero", 6'b000000, 0, 0);
        step();
        idle_in();
        chk("t5_zero_next", 6'b000000, 0, 0);
        step();
        bus.ex_multi_start = 1'b1;
        bus.ex_multi_cycles = 6'd2;
        chk("t5_c1", 6'b001111, 0, 0);
        step();
        bus.ex_multi_cycles = 6'd9;
        chk("t5_c2", 6'b001111, 1, 0);
        step();
        idle_in();
        chk("t5_c3", 6'b000000, 0, 1);
        step();
        chk("t5_c4", 6'b000000, 0, 0);

        // Counter saturation and clear priority
        bus.perf_clr = 1'b1;
        step();
        idle_in();
        #1;
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        preload_now = 1'b1;
        #1;
        release dut.cycle_cnt;
        step();
        preload_now = 1'b0;
        check("t6_preload", 64'(bus.stall_cycles), 64'hFFFF_FFFE);
        bus.stallreq_from_if = 1'b1;
        step();
        step();
        step();
        bus.stallreq_from_if = 1'b0;
        #1;
        check("t6_sat", 64'(bus.stall_cycles), 64'hFFFF_FFFF);
        step();
        bus.stallreq_from_if = 1'b1;
        bus.perf_clr = 1'b1;
        step();
        idle_in();
        #1;
        check("t6_clr", 64'(bus.stall_cycles), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            bus.stallreq_from_if  = ($urandom_range(0, 5) == 0);
            bus.stallreq_from_id  = ($urandom_range(0, 7) == 0);
            bus.stallreq_from_ex  = ($urandom_range(0, 9) == 0);
            bus.stallreq_from_mem = ($urandom_range(0, 4) == 0);
            bus.ex_multi_start    = ($urandom_range(0, 3) == 0);
            bus.ex_multi_cycles   = 6'($urandom_range(0, 12));
            bus.perf_clr          = ($urandom_range(0, 99) == 0);
        end
        step();
        rst = 1'b0;
        idle_in();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
